// File: rtl/data_bus_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter_2to1
//
// Round-robin arbiter and sequencer for a shared 2-to-1 data bus. Two
// requesters each present a word and a request line. One requester owns the
// bus at a time. The owner's word is registered onto dataOut with a valid
// strobe one edge after each grant cycle. A hold limit forces a handover
// when the owner has held the bus for MAX_HOLD consecutive cycles and the
// other side is still requesting.
//
// Optional feature macro: DATA_BUS_ARB_PARITY_EN
//   When defined, the design adds port parityOut, which carries the even
//   parity of dataOut and is registered together with it.
//
// Parameters
//   WIDTH     data word width in bits
//   MAX_HOLD  maximum consecutive grant cycles while the other side requests (>=1)
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   synchronous active-high reset; overrides everything
//   req1/req2  in   request lines of requester 1 / 2
//   data1/2    in   words of requester 1 / 2
//   grant1/2   out  requester 1 / 2 owns the bus this cycle (registered)
//   select     out  mux select, 0=data1, 1=data2, holds while idle (registered)
//   dataOut    out  registered bus word
//   valid      out  dataOut was loaded at the last edge
//   parityOut  out  even parity of dataOut (DATA_BUS_ARB_PARITY_EN only)
// -----------------------------------------------------------------------------
module data_bus_arbiter_2to1 #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req1,
  input  logic             req2,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             grant1,
  output logic             grant2,
  output logic             select,
  output logic [WIDTH-1:0] dataOut,
`ifdef DATA_BUS_ARB_PARITY_EN
  output logic             valid,
  output logic             parityOut
`else
  output logic             valid
`endif
);

  // A counter of at least one bit, even when MAX_HOLD is 1.
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G1   = 2'd1,
    G2   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [CNT_W-1:0] hold_cnt_s;
  logic             last_g2_r;   // 1: requester 2 was granted most recently
  logic             last_g2_s;
  logic             grant1_r;
  logic             grant2_r;
  logic             select_r;
  logic [WIDTH-1:0] data_out_r;
  logic             valid_r;

  // Even parity of a word: XOR-reduction, 1 when the word has an odd number of ones.
  function automatic logic parity_even(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  // Next-state, hold counter and round-robin memory.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    last_g2_s  = last_g2_r;
    case (state_r)
      IDLE: begin
        if (req1 && req2) begin
          // Tie goes to the side that was not granted last.
          state_s = last_g2_r ? G1 : G2;
        end else if (req1) begin
          state_s = G1;
        end else if (req2) begin
          state_s = G2;
        end else begin
          state_s = IDLE;
        end
      end
      G1: begin
        if (!req1) begin
          state_s = req2 ? G2 : IDLE;
        end else if (req2 && (hold_cnt_r == HOLD_LAST)) begin
          state_s = G2;
        end else begin
          state_s = G1;
        end
      end
      G2: begin
        if (!req2) begin
          state_s = req1 ? G1 : IDLE;
        end else if (req1 && (hold_cnt_r == HOLD_LAST)) begin
          state_s = G1;
        end else begin
          state_s = G2;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if ((state_s != state_r) && (state_s != IDLE)) begin
      // Fresh grant: restart the hold window and remember the owner.
      hold_cnt_s = {CNT_W{1'b0}};
      last_g2_s  = (state_s == G2);
    end else if ((state_s == state_r) && (state_r != IDLE) && (hold_cnt_r != HOLD_LAST)) begin
      hold_cnt_s = hold_cnt_r + CNT_W'(1);
    end else begin
      hold_cnt_s = hold_cnt_r;
    end
  end

  // Arbitration state, grants and select; grants and select decode the next state
  // so they stay exactly aligned with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      hold_cnt_r <= {CNT_W{1'b0}};
      last_g2_r  <= 1'b1;
      grant1_r   <= 1'b0;
      grant2_r   <= 1'b0;
      select_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      last_g2_r  <= last_g2_s;
      grant1_r   <= (state_s == G1);
      grant2_r   <= (state_s == G2);
      case (state_s)
        G1:      select_r <= 1'b0;
        G2:      select_r <= 1'b1;
        default: select_r <= select_r;
      endcase
    end
  end

  // Output word: load the owner's word after each grant cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_r <= {WIDTH{1'b0}};
      valid_r    <= 1'b0;
    end else begin
      case (state_r)
        G1: begin
          data_out_r <= data1;
          valid_r    <= 1'b1;
        end
        G2: begin
          data_out_r <= data2;
          valid_r    <= 1'b1;
        end
        default: begin
          data_out_r <= data_out_r;
          valid_r    <= 1'b0;
        end
      endcase
    end
  end

`ifdef DATA_BUS_ARB_PARITY_EN
  logic parity_r;

  // Parity bit loaded in step with dataOut so the two always agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_r <= 1'b0;
    end else begin
      case (state_r)
        G1:      parity_r <= parity_even(data1);
        G2:      parity_r <= parity_even(data2);
        default: parity_r <= parity_r;
      endcase
    end
  end

  assign parityOut = parity_r;
`endif

  assign grant1  = grant1_r;
  assign grant2  = grant2_r;
  assign select  = select_r;
  assign dataOut = data_out_r;
  assign valid   = valid_r;

endmodule

// File: tb/tb_data_bus_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// Testbench for data_bus_arbiter_2to1. A reference model tracks the bus owner,
// its run length and the round-robin memory. Every grant cycle pushes the word
// that must appear on dataOut; a monitor pops one entry per valid strobe.
// -----------------------------------------------------------------------------
module tb_data_bus_arbiter_2to1;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk;
  logic             reset;
  logic             req1;
  logic             req2;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             grant1;
  logic             grant2;
  logic             select;
  logic [WIDTH-1:0] dataOut;
  logic             valid;
`ifdef DATA_BUS_ARB_PARITY_EN
  logic             parityOut;
`endif

  data_bus_arbiter_2to1 #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .reset(reset),
    .req1(req1),
    .req2(req2),
    .data1(data1),
    .data2(data2),
    .grant1(grant1),
    .grant2(grant2),
    .select(select),
    .dataOut(dataOut),
`ifdef DATA_BUS_ARB_PARITY_EN
    .valid(valid),
    .parityOut(parityOut)
`else
    .valid(valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];

  // Reference model: owner 0=none, 1, 2; run = consecutive cycles owned.
  int   owner    = 0;
  int   last_own = 2;
  int   run      = 0;
  logic sel_m    = 1'b0;
  logic prev_rst = 1'b0;
  int   cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: check visible state, drive new inputs, advance the model.
  task automatic step(input logic r, input logic q1, input logic q2);
    int nxt;
    if (cyc > 0) begin
      chk("grant1", {31'd0, grant1}, {31'd0, (owner == 1)});
      chk("grant2", {31'd0, grant2}, {31'd0, (owner == 2)});
      chk("select", {31'd0, select}, {31'd0, sel_m});
    end
    if (prev_rst) begin
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_data", {24'd0, dataOut}, 32'd0);
`ifdef DATA_BUS_ARB_PARITY_EN
      chk("rst_parity", {31'd0, parityOut}, 32'd0);
`endif
    end
    reset = r;
    req1  = q1;
    req2  = q2;
    data1 = WIDTH'($urandom);
    data2 = WIDTH'($urandom);
    if (r) begin
      owner    = 0;
      last_own = 2;
      run      = 0;
      sel_m    = 1'b0;
    end else begin
      if (owner == 1) exp_q.push_back(data1);
      else if (owner == 2) exp_q.push_back(data2);
      nxt = owner;
      if (owner == 0) begin
        if (q1 && q2) nxt = (last_own == 1) ? 2 : 1;
        else if (q1) nxt = 1;
        else if (q2) nxt = 2;
      end else begin
        logic mine;
        logic other;
        mine  = (owner == 1) ? q1 : q2;
        other = (owner == 1) ? q2 : q1;
        if (!mine) nxt = other ? 3 - owner : 0;
        else if (other && run >= MAX_HOLD) nxt = 3 - owner;
      end
      if (nxt != 0 && nxt != owner) begin
        run      = 1;
        last_own = nxt;
      end else if (nxt != 0) begin
        run++;
      end else begin
        run = 0;
      end
      owner = nxt;
      if (owner == 1) sel_m = 1'b0;
      else if (owner == 2) sel_m = 1'b1;
    end
    prev_rst = r;
    cyc++;
    @(negedge clk);
  endtask

  // Monitor: every valid strobe must deliver the oldest expected word.
  initial begin
    logic [WIDTH-1:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got dataOut %0h expected no word (t=%0t)", dataOut, $time);
        end else begin
          w = exp_q.pop_front();
          chk("dataOut", {24'd0, dataOut}, {24'd0, w});
`ifdef DATA_BUS_ARB_PARITY_EN
          chk("parityOut", {31'd0, parityOut}, {31'd0, ^w});
`endif
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    req1  = 1'b0;
    req2  = 1'b0;
    data1 = '0;
    data2 = '0;
    @(negedge clk);
    // Reset for 2 cycles, then idle.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    chk("idle_valid", {31'd0, valid}, 32'd0);
    // Requester 1 alone, then both continuously (hold-limit rotation).
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
    // Requester 1 drops while 2 keeps asking: direct handover.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    // Reset during G2, then a tie that must go to requester 1.
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
